// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path and its ALU control.
package ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    // Supported opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_R    = 6'h00;
    localparam logic [OP_W-1:0] OP_J    = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE  = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI = 6'h0A;
    localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW   = 6'h23;
    localparam logic [OP_W-1:0] OP_SW   = 6'h2B;

    // Controller state codes, visible on state_o
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_e;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the datapath can execute
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_SLTI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ext_op_decode.sv
// Immediate extender mode: ORI zero-extends, everything else sign-extends.
module ext_op_decode
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output logic            ext_op_o
);

    // Only the logical-immediate opcode needs zero extension
    always_comb begin
        ext_op_o = (op_i != OP_ORI);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset datapath.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [5:0]         funct_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               ir_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               iord_o,
    output logic               reg_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [1:0]         alu_op_o,
    output logic               ext_op_o,
    output logic [1:0]         pc_src_o,
    output logic               illegal_o,
    output logic               instr_done_o,
    output logic [CNT_W-1:0]   instr_cnt_o,
    output logic [STATE_W-1:0] state_o
);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               ext_op_c;

    // funct only matters to the ALU control block downstream
    logic               unused_funct;
    assign unused_funct = ^funct_i;

    ext_op_decode u_ext_op_decode (
        .op_i     (op_i),
        .ext_op_o (ext_op_c)
    );

    // State and retire-counter registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state sequencing, including memory-ready stalls
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW:           state_d = S_MEM_ADDR;
                    OP_R:                   state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE:         state_d = S_BRANCH;
                    OP_J:                   state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ORI: state_d = S_I_EXEC;
                    default:                state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (op_i == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (op_i == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD:   state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_I_EXEC:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the current state; forced low during reset
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_REG;
        alu_op_o     = ALUOP_ADD;
        ext_op_o     = 1'b0;
        pc_src_o     = PCSRC_ALU;
        illegal_o    = 1'b0;
        instr_done_o = 1'b0;
        state_o      = '0;
        if (!rst_i) begin
            state_o = STATE_W'(state_q);
            case (state_q)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = SRCB_FOUR;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o = SRCB_IMM_SH;
                    ext_op_o    = ext_op_c;
                    illegal_o   = !is_legal_op(op_i);
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRCB_IMM;
                    ext_op_o    = 1'b1;
                end
                S_MEM_RD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write_o  = 1'b1;
                    iord_o       = 1'b1;
                    instr_done_o = mem_ready_i;
                end
                S_R_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o  = 1'b1;
                    alu_op_o     = ALUOP_SUB;
                    pc_src_o     = PCSRC_ALUOUT;
                    pc_write_o   = ((op_i == OP_BEQ) && zero_i) ||
                                   ((op_i == OP_BNE) && !zero_i);
                    instr_done_o = 1'b1;
                end
                S_JUMP: begin
                    pc_write_o   = 1'b1;
                    pc_src_o     = PCSRC_JUMP;
                    instr_done_o = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRCB_IMM;
                    ext_op_o    = ext_op_c;
                    alu_op_o    = (op_i == OP_ADDI) ? ALUOP_ADD : ALUOP_IMM;
                end
                S_I_WB: begin
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                end
                default: begin
                    state_o = '0;
                end
            endcase
        end
    end

    // Retire counter advances on every done cycle and wraps naturally
    always_comb begin
        cnt_d = cnt_q;
        if (instr_done_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        instr_cnt_o = rst_i ? '0 : cnt_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction reference traces vs observed outputs.
module tb_multicycle_ctrl;

    localparam logic [5:0] T_R    = 6'h00;
    localparam logic [5:0] T_J    = 6'h02;
    localparam logic [5:0] T_BEQ  = 6'h04;
    localparam logic [5:0] T_BNE  = 6'h05;
    localparam logic [5:0] T_ADDI = 6'h08;
    localparam logic [5:0] T_SLTI = 6'h0A;
    localparam logic [5:0] T_ORI  = 6'h0D;
    localparam logic [5:0] T_LW   = 6'h23;
    localparam logic [5:0] T_SW   = 6'h2B;

    typedef struct packed {
        logic [3:0]  state;
        logic        pc_write;
        logic        ir_write;
        logic        mem_read;
        logic        mem_write;
        logic        iord;
        logic        reg_write;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [1:0]  alu_op;
        logic        ext_op;
        logic [1:0]  pc_src;
        logic        illegal;
        logic        done;
        logic [31:0] cnt;
    } obs_t;

    logic        clk;
    logic        rst_i;
    logic [5:0]  op_i;
    logic [5:0]  funct_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o;
    logic        reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
    logic [1:0]  alu_src_b_o, alu_op_o, pc_src_o;
    logic        ext_op_o, illegal_o, instr_done_o;
    logic [31:0] instr_cnt_o;
    logic [3:0]  state_o;

    obs_t        sb[$];
    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_cnt;
    int          n_instr;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .op_i         (op_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .ir_write_o   (ir_write_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .iord_o       (iord_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .ext_op_o     (ext_op_o),
        .pc_src_o     (pc_src_o),
        .illegal_o    (illegal_o),
        .instr_done_o (instr_done_o),
        .instr_cnt_o  (instr_cnt_o),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected observation skeleton for one cycle in a given phase
    function automatic obs_t blank(input logic [3:0] s);
        obs_t e;
        e       = '0;
        e.state = s;
        e.cnt   = exp_cnt;
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the controller must show during it
    task automatic cyc(input logic rst, input logic [5:0] op, input logic z,
                       input logic rdy, input obs_t e);
        rst_i       = rst;
        op_i        = op;
        zero_i      = z;
        mem_ready_i = rdy;
        funct_i     = 6'($urandom);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 6'($urandom), 1'($urandom), 1'($urandom), obs_t'(0));
        end
        exp_cnt = '0;
    endtask

    // Reference behaviour of one instruction: fw fetch stalls, mw memory stalls,
    // optional reset after the first memory stall of a load
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw,
                             input int mw, input bit abort);
        obs_t e;
        logic legal;
        legal = (op == T_R) || (op == T_J) || (op == T_BEQ) || (op == T_BNE) ||
                (op == T_ADDI) || (op == T_SLTI) || (op == T_ORI) ||
                (op == T_LW) || (op == T_SW);
        for (int i = 0; i <= fw; i++) begin
            e           = blank(4'd0);
            e.mem_read  = 1'b1;
            e.alu_src_b = 2'b01;
            e.ir_write  = (i == fw);
            e.pc_write  = (i == fw);
            cyc(1'b0, 6'($urandom), 1'($urandom), (i == fw), e);
        end
        e           = blank(4'd1);
        e.alu_src_b = 2'b11;
        e.ext_op    = (op != T_ORI);
        e.illegal   = !legal;
        cyc(1'b0, op, 1'($urandom), 1'($urandom), e);
        if (!legal) return;

        if (op == T_LW || op == T_SW) begin
            e           = blank(4'd2);
            e.alu_src_a = 1'b1;
            e.alu_src_b = 2'b10;
            e.ext_op    = 1'b1;
            cyc(1'b0, op, 1'($urandom), 1'($urandom), e);
            for (int i = 0; i <= mw; i++) begin
                if (abort && i == 1) begin
                    reset_cycles(2);
                    return;
                end
                e        = blank((op == T_LW) ? 4'd3 : 4'd5);
                e.iord   = 1'b1;
                if (op == T_LW) e.mem_read = 1'b1;
                else            e.mem_write = 1'b1;
                e.done   = (op == T_SW) && (i == mw);
                cyc(1'b0, op, 1'($urandom), (i == mw), e);
            end
            if (op == T_LW) begin
                e            = blank(4'd4);
                e.reg_write  = 1'b1;
                e.mem_to_reg = 1'b1;
                e.done       = 1'b1;
                cyc(1'b0, op, 1'($urandom), 1'($urandom), e);
            end
        end else if (op == T_R) begin
            e           = blank(4'd6);
            e.alu_src_a = 1'b1;
            e.alu_op    = 2'b10;
            cyc(1'b0, op, 1'($urandom), 1'($urandom), e);
            e           = blank(4'd7);
            e.reg_write = 1'b1;
            e.reg_dst   = 1'b1;
            e.done      = 1'b1;
            cyc(1'b0, op, 1'($urandom), 1'($urandom), e);
        end else if (op == T_BEQ || op == T_BNE) begin
            e           = blank(4'd8);
            e.alu_src_a = 1'b1;
            e.alu_op    = 2'b01;
            e.pc_src    = 2'b01;
            e.pc_write  = (op == T_BEQ) ? z : !z;
            e.done      = 1'b1;
            cyc(1'b0, op, z, 1'($urandom), e);
        end else if (op == T_J) begin
            e          = blank(4'd9);
            e.pc_write = 1'b1;
            e.pc_src   = 2'b10;
            e.done     = 1'b1;
            cyc(1'b0, op, 1'($urandom), 1'($urandom), e);
        end else begin
            e           = blank(4'd10);
            e.alu_src_a = 1'b1;
            e.alu_src_b = 2'b10;
            e.ext_op    = (op != T_ORI);
            e.alu_op    = (op == T_ADDI) ? 2'b00 : 2'b11;
            cyc(1'b0, op, 1'($urandom), 1'($urandom), e);
            e           = blank(4'd11);
            e.reg_write = 1'b1;
            e.done      = 1'b1;
            cyc(1'b0, op, 1'($urandom), 1'($urandom), e);
        end
        exp_cnt = exp_cnt + 32'd1;
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge clk) begin
        obs_t act;
        obs_t exp_o;
        if (sb.size() > 0) begin
            exp_o          = sb.pop_front();
            act.state      = state_o;
            act.pc_write   = pc_write_o;
            act.ir_write   = ir_write_o;
            act.mem_read   = mem_read_o;
            act.mem_write  = mem_write_o;
            act.iord       = iord_o;
            act.reg_write  = reg_write_o;
            act.reg_dst    = reg_dst_o;
            act.mem_to_reg = mem_to_reg_o;
            act.alu_src_a  = alu_src_a_o;
            act.alu_src_b  = alu_src_b_o;
            act.alu_op     = alu_op_o;
            act.ext_op     = ext_op_o;
            act.pc_src     = pc_src_o;
            act.illegal    = illegal_o;
            act.done       = instr_done_o;
            act.cnt        = instr_cnt_o;
            tests_run++;
            if (act !== exp_o) begin
                tests_failed++;
                $display("FAIL cycle_trace t=%0t state got %0d exp %0d, cnt got %0d exp %0d, ctrl got %h exp %h",
                         $time, act.state, exp_o.state, act.cnt, exp_o.cnt,
                         act[50:32], exp_o[50:32]);
            end
        end
    end

    initial begin
        logic [5:0] ops [12];
        logic [5:0] op;
        tests_run    = 0;
        tests_failed = 0;
        exp_cnt      = '0;
        ops = '{T_R, T_J, T_BEQ, T_BNE, T_ADDI, T_SLTI, T_ORI, T_LW, T_SW,
                6'h3F, 6'h01, 6'h2A};
        rst_i       = 1'b1;
        op_i        = '0;
        funct_i     = '0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b0;
        @(posedge clk);
        #1;
        reset_cycles(2);

        // Directed scenarios
        run_instr(T_R,    1'b0, 0, 0, 1'b0);
        run_instr(T_LW,   1'b0, 0, 2, 1'b0);
        run_instr(T_BEQ,  1'b1, 0, 0, 1'b0);
        run_instr(T_BNE,  1'b1, 0, 0, 1'b0);
        run_instr(T_ORI,  1'b0, 0, 0, 1'b0);
        run_instr(T_ADDI, 1'b0, 0, 0, 1'b0);
        run_instr(6'h3F,  1'b0, 2, 0, 1'b0);
        run_instr(T_SW,   1'b0, 1, 1, 1'b0);
        run_instr(T_LW,   1'b0, 0, 3, 1'b1);
        run_instr(T_J,    1'b0, 0, 0, 1'b0);

        // Randomized instruction stream
        n_instr = 200;
        for (int k = 0; k < n_instr; k++) begin
            op = ops[$urandom_range(0, 11)];
            run_instr(op, 1'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)),
                      ((op == T_LW) && ($urandom_range(0, 15) == 0)));
        end

        @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
